vga_frame_reader: RTL



---
 rtl/vga_frame_reader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA timing generator that streams a 2x-upscaled RGB444 frame buffer.
// Optional colour-bar source enabled by defining VGA_FRAME_READER_TEST_PATTERN_EN.
`timescale 1ns/1ps
module vga_frame_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int FB_W        = 320,
  parameter int SCALE_SHIFT = 1,
  parameter int RD_LAT      = 2,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [11:0]       pix_out,
  output logic              nblank,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] ROW_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] FB_W_C = ADDR_W'(FB_W);

  typedef struct packed {
    logic          act;
    logic          hs_n;
    logic          vs_n;
    logic          fs;
`ifdef VGA_FRAME_READER_TEST_PATTERN_EN
    logic [HW-1:0] h;
`endif
  } tim_t;

  function automatic tim_t tim_idle();
    tim_t t;
    t      = '0;
    t.hs_n = 1'b1;
    t.vs_n = 1'b1;
    return t;
  endfunction

  logic [HW-1:0]     h_cnt_reg;
  logic [VW-1:0]     v_cnt_reg;
  logic [VW-1:0]     v_cnt_next;
  logic [ADDR_W-1:0] line_base_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] rd_addr_next;
  logic              act_raw;
  tim_t              tim_raw;
  tim_t              tim_out;
  tim_t              dly_reg [0:RD_LAT];

  assign v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : VW'(v_cnt_reg + 1'b1);

  // line_base_reg always holds (v_cnt >> SCALE_SHIFT) * FB_W for the current line,
  // so the address needs only one add per pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      line_base_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= v_cnt_next;
      if (v_cnt_next == '0)
        line_base_reg <= '0;
      else if (((v_cnt_next & ROW_MASK) == '0) && (v_cnt_next < V_ACT_C))
        line_base_reg <= line_base_reg + FB_W_C;
    end else begin
      h_cnt_reg <= HW'(h_cnt_reg + 1'b1);
    end
  end

  assign act_raw      = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
  assign rd_addr_next = act_raw ? (line_base_reg + ADDR_W'(h_cnt_reg >> SCALE_SHIFT)) : '0;

  always_comb begin
    tim_raw      = tim_idle();
    tim_raw.act  = act_raw;
    tim_raw.hs_n = !((h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST));
    tim_raw.vs_n = !((v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST));
    tim_raw.fs   = (h_cnt_reg == '0) && (v_cnt_reg == '0);
`ifdef VGA_FRAME_READER_TEST_PATTERN_EN
    tim_raw.h    = h_cnt_reg;
`endif
  end

  // Stage 0 lines up with rd_addr; the RD_LAT stages after it cover the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_reg <= '0;
      dly_reg[0]  <= tim_idle();
    end else begin
      rd_addr_reg <= rd_addr_next;
      dly_reg[0]  <= tim_raw;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= RD_LAT; gi++) begin : g_dly
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          dly_reg[gi] <= tim_idle();
        else
          dly_reg[gi] <= dly_reg[gi-1];
      end
    end
  endgenerate

  assign tim_out     = dly_reg[RD_LAT];
  assign rd_addr     = rd_addr_reg;
  assign nblank      = tim_out.act;
  assign hsync_n     = tim_out.hs_n;
  assign vsync_n     = tim_out.vs_n;
  assign frame_start = tim_out.fs;

`ifdef VGA_FRAME_READER_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0]  bar;
  logic [11:0] pix_src;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (tim_out.h >= HW'(k * BAR_W))
        bar = 3'(k);
  end

  assign pix_src = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`else
  logic [11:0] pix_src;
  assign pix_src = rd_data;
`endif

  // Gate with the delayed blank so stale RAM data never leaks into blanking.
  assign pix_out = tim_out.act ? pix_src : 12'h000;

endmodule
